solver_drain: RTL and testbench

- Downstream consumer of the multi-solver array.
- After a frame completes, it walks every solver's result memory through the rd_solver_id/rd_addr read port, in solver-major then address-ascending order.
- Each iteration count is forwarded as a linear framebuffer write over a valid/ready stream.
- It is the only block that drives the solver read port during drain.

---
 rtl/solver_drain_if.sv | 27 ++
 rtl/solver_drain.sv | 162 ++++++++++++++++
 tb/tb_solver_drain.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/solver_drain_if.sv
// Read-port and framebuffer-stream bundle between solver_drain, the
// multi-solver result memories and the framebuffer writer.
// master: the drain engine. slave: the memory/framebuffer side.
interface solver_drain_if #(
    parameter int SOLVER_ID_WIDTH = 6,
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 8,
    parameter int FB_ADDR_WIDTH   = 16
);
    logic [SOLVER_ID_WIDTH-1:0] rd_solver_id;
    logic [ADDR_WIDTH-1:0]      rd_addr;
    logic [DATA_WIDTH-1:0]      rd_data;
    logic                       fb_valid;
    logic                       fb_ready;
    logic [FB_ADDR_WIDTH-1:0]   fb_addr;
    logic [DATA_WIDTH-1:0]      fb_data;

    modport master (
        output rd_solver_id, rd_addr, fb_valid, fb_addr, fb_data,
        input  rd_data, fb_ready
    );

    modport slave (
        input  rd_solver_id, rd_addr, fb_valid, fb_addr, fb_data,
        output rd_data, fb_ready
    );
endinterface

// File: rtl/solver_drain.sv
// solver_drain: after a frame, walks every solver result memory in
// solver-major / address-ascending order and forwards each iteration
// count as a linear framebuffer write on a valid/ready stream.
// Optional feature macro: SOLVER_DRAIN_CHECKSUM_EN adds a running
// modulo-2**(DATA_WIDTH+8) sum of all accepted fb_data words.
module solver_drain #(
    parameter int NUM_SOLVERS      = 2,
    parameter int SOLVER_ID_WIDTH  = 6,
    parameter int ADDR_WIDTH       = 10,
    parameter int WORDS_PER_SOLVER = 1024,
    parameter int DATA_WIDTH       = 8,
    parameter int FB_ADDR_WIDTH    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    solver_drain_if.master          bus
`ifdef SOLVER_DRAIN_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH+7:0]   checksum
`endif
);
    localparam int FW = FB_ADDR_WIDTH + SOLVER_ID_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        PUSH    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                     state_r, state_s;
    logic [SOLVER_ID_WIDTH-1:0] id_r, id_s;
    logic [ADDR_WIDTH-1:0]      addr_r, addr_s;
    logic                       busy_r, busy_s;
    logic                       done_r, done_s;
    logic                       fb_valid_r, fb_valid_s;
    logic [FB_ADDR_WIDTH-1:0]   fb_addr_r, fb_addr_s;
    logic [DATA_WIDTH-1:0]      fb_data_r, fb_data_s;
    logic [FW-1:0]              fb_addr_wide_s;
    logic                       addr_last_s;
    logic                       word_last_s;
`ifdef SOLVER_DRAIN_CHECKSUM_EN
    logic [DATA_WIDTH+7:0]      csum_r, csum_s;
`endif

    // Linear framebuffer address and end-of-range flags for the current word
    always_comb begin
        fb_addr_wide_s = FW'(id_r) * FW'(WORDS_PER_SOLVER) + FW'(addr_r);
        addr_last_s    = (addr_r == ADDR_WIDTH'(WORDS_PER_SOLVER - 1));
        word_last_s    = addr_last_s && (id_r == SOLVER_ID_WIDTH'(NUM_SOLVERS - 1));
    end

    // Next-state, counter and output-register computation
    always_comb begin
        state_s    = state_r;
        id_s       = id_r;
        addr_s     = addr_r;
        fb_valid_s = fb_valid_r;
        fb_addr_s  = fb_addr_r;
        fb_data_s  = fb_data_r;
`ifdef SOLVER_DRAIN_CHECKSUM_EN
        csum_s     = csum_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ISSUE;
                    id_s    = {SOLVER_ID_WIDTH{1'b0}};
                    addr_s  = {ADDR_WIDTH{1'b0}};
`ifdef SOLVER_DRAIN_CHECKSUM_EN
                    csum_s  = {(DATA_WIDTH+8){1'b0}};
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                // address is already on the read port; data returns next cycle
                state_s = CAPTURE;
            end
            CAPTURE: begin
                fb_data_s  = bus.rd_data;
                fb_addr_s  = fb_addr_wide_s[FB_ADDR_WIDTH-1:0];
                fb_valid_s = 1'b1;
                state_s    = PUSH;
            end
            PUSH: begin
                if (bus.fb_ready) begin
                    fb_valid_s = 1'b0;
`ifdef SOLVER_DRAIN_CHECKSUM_EN
                    csum_s = csum_r + {8'h00, fb_data_r};
`endif
                    if (word_last_s) begin
                        state_s = DONE;
                    end else if (addr_last_s) begin
                        addr_s  = {ADDR_WIDTH{1'b0}};
                        id_s    = id_r + {{(SOLVER_ID_WIDTH-1){1'b0}}, 1'b1};
                        state_s = ISSUE;
                    end else begin
                        addr_s  = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = PUSH;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s    = IDLE;
                fb_valid_s = 1'b0;
            end
        endcase
        busy_s = (state_s == ISSUE) || (state_s == CAPTURE) || (state_s == PUSH);
        done_s = (state_s == DONE);
    end

    // State, counters and registered outputs; reset abandons any drain
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            id_r       <= {SOLVER_ID_WIDTH{1'b0}};
            addr_r     <= {ADDR_WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            fb_valid_r <= 1'b0;
            fb_addr_r  <= {FB_ADDR_WIDTH{1'b0}};
            fb_data_r  <= {DATA_WIDTH{1'b0}};
`ifdef SOLVER_DRAIN_CHECKSUM_EN
            csum_r     <= {(DATA_WIDTH+8){1'b0}};
`endif
        end else begin
            state_r    <= state_s;
            id_r       <= id_s;
            addr_r     <= addr_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            fb_valid_r <= fb_valid_s;
            fb_addr_r  <= fb_addr_s;
            fb_data_r  <= fb_data_s;
`ifdef SOLVER_DRAIN_CHECKSUM_EN
            csum_r     <= csum_s;
`endif
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign bus.rd_solver_id = id_r;
    assign bus.rd_addr      = addr_r;
    assign bus.fb_valid     = fb_valid_r;
    assign bus.fb_addr      = fb_addr_r;
    assign bus.fb_data      = fb_data_r;
`ifdef SOLVER_DRAIN_CHECKSUM_EN
    assign checksum         = csum_r;
`endif
endmodule

// File: tb/tb_solver_drain.sv
// Directed testbench for solver_drain with NUM_SOLVERS=2, WORDS_PER_SOLVER=4.
// The memory model returns {id[1:0], addr[5:0]} one cycle after the address.
// Define SOLVER_DRAIN_CHECKSUM_EN to also exercise the checksum output.
module tb_solver_drain;
    localparam int NS  = 2;
    localparam int WPS = 4;

    logic clock;
    logic reset;
    logic start;
    logic busy;
    logic done;
`ifdef SOLVER_DRAIN_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int passed;
    int total;

    solver_drain_if #(.SOLVER_ID_WIDTH(6), .ADDR_WIDTH(10), .DATA_WIDTH(8),
                      .FB_ADDR_WIDTH(16)) bus ();

    solver_drain #(
        .NUM_SOLVERS(NS), .SOLVER_ID_WIDTH(6), .ADDR_WIDTH(10),
        .WORDS_PER_SOLVER(WPS), .DATA_WIDTH(8), .FB_ADDR_WIDTH(16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
`ifdef SOLVER_DRAIN_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    // free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // synchronous-read result memory model
    always @(posedge clock) begin
        bus.rd_data <= {bus.rd_solver_id[1:0], bus.rd_addr[5:0]};
    end

    function automatic logic [7:0] exp_data(input int k);
        logic [7:0] v;
        v = 8'((k / WPS) * 64 + (k % WPS));
        return v;
    endfunction

    // One drain. stall_word/stall_len: backpressure on that fb_addr.
    // restart_word: pulse start while that word is being pushed.
    task automatic run_drain(input int stall_word, input int stall_len,
                             input int restart_word, input int exp_done,
                             input string tag);
        int cyc;
        int words;
        int held;
        int stalls;
        int done_cyc;
        bit restarted;
        cyc = 0; words = 0; held = 0; stalls = 0; done_cyc = -1; restarted = 1'b0;
        bus.fb_ready = 1'b1;
        start = 1'b1;
        while (done_cyc < 0 && cyc < 80) begin
            @(posedge clock);
            #1;
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                total++;
                if (busy !== 1'b1) $display("FAIL %s busy_after_start got=%b exp=1", tag, busy);
                else passed++;
`ifdef SOLVER_DRAIN_CHECKSUM_EN
                total++;
                if (checksum !== 16'h0000) $display("FAIL %s csum_clear got=%h exp=0000", tag, checksum);
                else passed++;
`endif
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                total++;
                if (busy !== 1'b0) $display("FAIL %s busy_at_done got=%b exp=0", tag, busy);
                else passed++;
`ifdef SOLVER_DRAIN_CHECKSUM_EN
                // 0+1+2+3 + 0x40+0x41+0x42+0x43 = 0x10C
                total++;
                if (checksum !== 16'h010C) $display("FAIL %s csum_final got=%h exp=010c", tag, checksum);
                else passed++;
`endif
            end
            if (bus.fb_valid === 1'b1 && int'(bus.fb_addr) == stall_word) begin
                held++;
                total++;
                if (bus.fb_data !== exp_data(stall_word) ||
                    int'(bus.rd_addr) != stall_word % WPS ||
                    int'(bus.rd_solver_id) != stall_word / WPS)
                    $display("FAIL %s stall_hold data=%h rd_addr=%0d rd_id=%0d exp data=%h addr=%0d id=%0d",
                             tag, bus.fb_data, bus.rd_addr, bus.rd_solver_id, exp_data(stall_word),
                             stall_word % WPS, stall_word / WPS);
                else passed++;
            end
            if (bus.fb_valid === 1'b1 && int'(bus.fb_addr) == stall_word && stalls < stall_len) begin
                bus.fb_ready = 1'b0;
                stalls++;
            end else begin
                bus.fb_ready = 1'b1;
            end
            if (!restarted && bus.fb_valid === 1'b1 && int'(bus.fb_addr) == restart_word) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (bus.fb_valid === 1'b1 && bus.fb_ready === 1'b1) begin
                total++;
                if (int'(bus.fb_addr) != words || bus.fb_data !== exp_data(words))
                    $display("FAIL %s write%0d addr=%0d data=%h exp addr=%0d data=%h",
                             tag, words, bus.fb_addr, bus.fb_data, words, exp_data(words));
                else passed++;
                words++;
            end
        end
        start = 1'b0;
        bus.fb_ready = 1'b1;
        total++;
        if (done_cyc != exp_done) $display("FAIL %s done_cycle got=%0d exp=%0d", tag, done_cyc, exp_done);
        else passed++;
        total++;
        if (words != NS * WPS) $display("FAIL %s word_count got=%0d exp=%0d", tag, words, NS * WPS);
        else passed++;
        if (stall_word >= 0) begin
            total++;
            if (held != stall_len + 1) $display("FAIL %s hold_cycles got=%0d exp=%0d", tag, held, stall_len + 1);
            else passed++;
        end
        @(posedge clock);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s after_done done=%b busy=%b exp 0/0", tag, done, busy);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        bus.fb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || bus.fb_valid !== 1'b0 || bus.rd_addr !== 10'd0 ||
                bus.rd_solver_id !== 6'd0 || bus.fb_addr !== 16'd0 || bus.fb_data !== 8'd0)
                $display("FAIL reset_hold busy=%b done=%b fb_valid=%b rd_addr=%0d exp all 0",
                         busy, done, bus.fb_valid, bus.rd_addr);
            else passed++;
        end
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || bus.fb_valid !== 1'b0 || bus.rd_addr !== 10'd0)
                $display("FAIL reset_release busy=%b done=%b fb_valid=%b rd_addr=%0d exp all 0",
                         busy, done, bus.fb_valid, bus.rd_addr);
            else passed++;
        end
    endtask

    task automatic test_full_drain();
        run_drain(-1, 0, -1, 25, "full");
    endtask

    task automatic test_backpressure();
        run_drain(5, 5, -1, 30, "bp");
    endtask

    task automatic test_start_ignored();
        run_drain(-1, 0, 3, 25, "restart");
    endtask

    task automatic test_reset_mid_drain();
        bit found;
        found = 1'b0;
        bus.fb_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            if (bus.fb_valid === 1'b1 && bus.fb_addr == 16'd2) begin
                bus.fb_ready = 1'b0;
                found = 1'b1;
            end
        end
        total++;
        if (!found) $display("FAIL midrst_reach_word2 got=timeout exp=word2 push");
        else passed++;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus.fb_valid !== 1'b0 || busy !== 1'b0 || bus.fb_addr !== 16'd0 ||
            bus.fb_data !== 8'd0 || bus.rd_addr !== 10'd0)
            $display("FAIL midrst_async fb_valid=%b busy=%b fb_addr=%0d rd_addr=%0d exp all 0",
                     bus.fb_valid, busy, bus.fb_addr, bus.rd_addr);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            total++;
            if (done !== 1'b0) $display("FAIL midrst_no_done got=%b exp=0", done);
            else passed++;
        end
        reset = 1'b1;
        bus.fb_ready = 1'b1;
        @(posedge clock);
        #1;
        run_drain(-1, 0, -1, 25, "after_rst");
    endtask

    task automatic test_back_to_back();
        run_drain(-1, 0, -1, 25, "b2b");
    endtask

    initial begin
        passed = 0;
        total = 0;
        reset = 1'b0;
        start = 1'b0;
        bus.fb_ready = 1'b1;
        #1;
        test_reset();
        test_full_drain();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_drain();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
